// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction-fetch front end for the 5-stage MIPS pipeline.
// Owns the fetch PC, issues one request per cycle to a synchronous instruction RAM
// and buffers returned {pc, instr} pairs in a DEPTH-entry FIFO that ID drains
// through a valid/ready handshake. ID redirects flush the queue and restart fetch.
// Optional feature macro: FETCH_BYPASS_EN. When it is defined, a word returning
// into an empty queue is presented to ID in the same cycle, which cuts one cycle
// from redirect-to-dequeue latency.
module fetch_queue #(
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   redirect_valid,
   input  logic [ADDR_W-1:0]      redirect_pc,
   output logic                   inst_ram_en,
   output logic [ADDR_W-1:0]      inst_ram_addr,
   input  logic [31:0]            inst_ram_rdata,
   output logic                   deq_valid,
   input  logic                   deq_ready,
   output logic [ADDR_W-1:0]      deq_pc,
   output logic [31:0]            deq_instr,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

   // Architectural state
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] mem_pc_q    [DEPTH];
   logic [31:0]       mem_instr_q [DEPTH];

   // Per-cycle control
   logic              issue;
   logic              wr_en;
   logic              pop;
   logic              bypass_take;
   logic [CNT_W:0]    occupancy;
   logic [ADDR_W-1:0] redirect_target;

   // Slots already promised: stored words plus the one still on its way back.
   assign occupancy       = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
   assign redirect_target = redirect_pc & ~ADDR_W'(3);

   assign issue         = !rst && !redirect_valid && (occupancy < DEPTH_EXT);
   assign inst_ram_en   = issue;
   assign inst_ram_addr = rst ? '0 : fetch_pc_q;
   assign count         = rst ? '0 : count_q;

   // Head presentation to ID: queue head first, else (optionally) the returning word.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      deq_valid = 1'b0;
      deq_pc    = '0;
      deq_instr = '0;
      if (!rst) begin
         if (count_q != '0) begin
            deq_valid = 1'b1;
            deq_pc    = mem_pc_q[rd_ptr_q];
            deq_instr = mem_instr_q[rd_ptr_q];
         end
`ifdef FETCH_BYPASS_EN
         else if (inflight_q && !redirect_valid) begin
            deq_valid = 1'b1;
            deq_pc    = inflight_pc_q;
            deq_instr = inst_ram_rdata;
         end
`endif
      end
   end

   // Handshake decode: pops from storage, consumption of the bypassed word, tail write.
   always_comb begin
      pop = deq_valid && deq_ready && !redirect_valid && (count_q != '0);
`ifdef FETCH_BYPASS_EN
      bypass_take = deq_valid && deq_ready && (count_q == '0);
`else
      bypass_take = 1'b0;
`endif
      wr_en = !rst && inflight_q && !redirect_valid && !bypass_take;
   end

   // Next-state computation; a redirect overrides every other update.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_target;
         inflight_d = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
      end
   end

   // State registers and FIFO storage, with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         // NOTE: the storage array is cleared on reset as well, so no stale word can ever be read back after reset.
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc_q[i]    <= '0;
            mem_instr_q[i] <= '0;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         if (wr_en) begin
            mem_pc_q[wr_ptr_q]    <= inflight_pc_q;
            mem_instr_q[wr_ptr_q] <= inst_ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue. A queue-based reference
// model of the fetch front end tracks the expected outputs every cycle, and
// scenario tasks add targeted checks for reset, stalls, redirects and wrap.
// Build with FETCH_BYPASS_EN defined to exercise the bypass configuration.
`timescale 1ns/1ps
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
`ifdef FETCH_BYPASS_EN
   localparam int          FIRST    = 1;  // first post-reset cycle with deq_valid
   localparam int          REDIR_LAT = 2;
`else
   localparam int          FIRST    = 2;
   localparam int          REDIR_LAT = 3;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_ram_en;
   logic [31:0] inst_ram_addr;
   logic [31:0] inst_ram_rdata;
   logic        deq_valid;
   logic        deq_ready;
   logic [31:0] deq_pc;
   logic [31:0] deq_instr;
   logic [2:0]  count;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: fetch PC, one outstanding request, and a queue of PCs.
   logic [31:0] mfetch;
   logic        mpend;
   logic [31:0] mpend_pc;
   logic [31:0] mq[$];

   always #5 clk = ~clk;

   fetch_queue #(
      .ADDR_W   (32),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_ram_en    (inst_ram_en),
      .inst_ram_addr  (inst_ram_addr),
      .inst_ram_rdata (inst_ram_rdata),
      .deq_valid      (deq_valid),
      .deq_ready      (deq_ready),
      .deq_pc         (deq_pc),
      .deq_instr      (deq_instr),
      .count          (count)
   );

   // Instruction RAM contents: a fixed scramble of the address.
   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return (pc * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
   endfunction

   // Apply inputs just after the falling edge and let combinational outputs settle.
   task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      deq_ready      = rdy;
      #1;
   endtask

   // Compare the DUT against the model, advance the model, clock, and answer the RAM request.
   task automatic tick();
      logic        e_en, e_valid, from_q, popped, req;
      logic [31:0] e_addr, e_pc, e_instr, addr;
      logic [2:0]  e_cnt;
      from_q  = (mq.size() > 0);
      e_valid = 1'b0;
      e_pc    = '0;
      if (!rst) begin
         if (from_q) begin
            e_valid = 1'b1;
            e_pc    = mq[0];
         end
`ifdef FETCH_BYPASS_EN
         else if (mpend && !redirect_valid) begin
            e_valid = 1'b1;
            e_pc    = mpend_pc;
         end
`endif
      end
      e_instr = e_valid ? instr_of(e_pc) : 32'h0;
      e_en    = !rst && !redirect_valid && ((mq.size() + int'(mpend)) < DEPTH);
      e_addr  = rst ? 32'h0 : mfetch;
      e_cnt   = rst ? 3'd0 : 3'(mq.size());

      vectors++;
      if (inst_ram_en !== e_en) begin
         miscompares++;
         $display("FAIL inst_ram_en @%0t: got %b, want %b", $time, inst_ram_en, e_en);
      end
      vectors++;
      if (inst_ram_addr !== e_addr) begin
         miscompares++;
         $display("FAIL inst_ram_addr @%0t: got %h, want %h", $time, inst_ram_addr, e_addr);
      end
      vectors++;
      if (deq_valid !== e_valid) begin
         miscompares++;
         $display("FAIL deq_valid @%0t: got %b, want %b", $time, deq_valid, e_valid);
      end
      vectors++;
      if (deq_pc !== e_pc) begin
         miscompares++;
         $display("FAIL deq_pc @%0t: got %h, want %h", $time, deq_pc, e_pc);
      end
      vectors++;
      if (deq_instr !== e_instr) begin
         miscompares++;
         $display("FAIL deq_instr @%0t: got %h, want %h", $time, deq_instr, e_instr);
      end
      vectors++;
      if (count !== e_cnt) begin
         miscompares++;
         $display("FAIL count @%0t: got %0d, want %0d", $time, count, e_cnt);
      end

      req  = inst_ram_en;
      addr = inst_ram_addr;

      if (rst) begin
         mfetch = RESET_PC;
         mpend  = 1'b0;
         mq.delete();
      end else if (redirect_valid) begin
         mfetch = {redirect_pc[31:2], 2'b00};
         mpend  = 1'b0;
         mq.delete();
      end else begin
         popped = e_valid && deq_ready;
         if (popped && from_q) void'(mq.pop_front());
         if (mpend && !(popped && !from_q)) mq.push_back(mpend_pc);
         mpend = e_en;
         if (e_en) begin
            mpend_pc = mfetch;
            mfetch   = mfetch + 32'd4;
         end
      end

      @(posedge clk);
      #1;
      inst_ram_rdata = req ? instr_of(addr) : $urandom();
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 32'h1234_5678, 1'b1);  // reset wins over redirect
      vectors++;
      if ({inst_ram_en, inst_ram_addr, deq_valid, deq_pc, deq_instr, count} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: en=%b addr=%h valid=%b pc=%h instr=%h count=%0d, want all zero",
                  inst_ram_en, inst_ram_addr, deq_valid, deq_pc, deq_instr, count);
      end
      tick();
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (inst_ram_en !== 1'b1 || inst_ram_addr !== RESET_PC) begin
         miscompares++;
         $display("FAIL first_fetch: en=%b addr=%h, want en=1 addr=%h", inst_ram_en, inst_ram_addr, RESET_PC);
      end
      tick();
   endtask

   task automatic test_streaming();
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1);
         if (i >= FIRST) begin
            vectors++;
            if (deq_valid !== 1'b1 || deq_pc !== RESET_PC + 32'(4 * (i - FIRST))) begin
               miscompares++;
               $display("FAIL stream_cycle%0d: valid=%b pc=%h, want valid=1 pc=%h",
                        i, deq_valid, deq_pc, RESET_PC + 32'(4 * (i - FIRST)));
            end
         end
         tick();
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      vectors++;
      if (count !== 3'd4 || inst_ram_en !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_full: count=%0d en=%b, want count=4 en=0", count, inst_ram_en);
      end
      tick();
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1);
         tick();
      end
   endtask

   task automatic test_redirect_mid();
      for (int i = 0; i < 20 && mq.size() != 3; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b0);
         tick();
      end
      vectors++;
      if (mq.size() != 3) begin
         miscompares++;
         $display("FAIL redirect_setup: queue never reached 3 entries (got %0d, want 3)", mq.size());
      end
      drive(1'b0, 1'b1, 32'hBFC0_0103, 1'b0);
      tick();
      // t+1
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (count !== 3'd0 || inst_ram_addr !== 32'hBFC0_0100 || inst_ram_en !== 1'b1 || deq_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL redirect_t1: count=%0d addr=%h en=%b valid=%b, want 0 bfc00100 1 0",
                  count, inst_ram_addr, inst_ram_en, deq_valid);
      end
      tick();
      // t+2
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (deq_valid !== (REDIR_LAT == 2)) begin
         miscompares++;
         $display("FAIL redirect_t2_valid: got %b, want %b", deq_valid, REDIR_LAT == 2);
      end
`ifdef FETCH_BYPASS_EN
      vectors++;
      if (deq_pc !== 32'hBFC0_0100) begin
         miscompares++;
         $display("FAIL redirect_t2_pc: got %h, want bfc00100", deq_pc);
      end
`endif
      tick();
`ifndef FETCH_BYPASS_EN
      // t+3
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (deq_valid !== 1'b1 || deq_pc !== 32'hBFC0_0100) begin
         miscompares++;
         $display("FAIL redirect_t3: valid=%b pc=%h, want 1 bfc00100", deq_valid, deq_pc);
      end
      tick();
`endif
   endtask

   task automatic test_collision();
      logic [31:0] target;
      logic        found;
      for (int i = 0; i < 10 && !(mpend && mq.size() > 0); i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1);
         tick();
      end
      target = $urandom();
      drive(1'b0, 1'b1, target, 1'b1);
      tick();
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1);
         if (deq_valid === 1'b1) begin
            found = 1'b1;
            vectors++;
            if (deq_pc !== {target[31:2], 2'b00}) begin
               miscompares++;
               $display("FAIL collision_first_pc: got %h, want %h", deq_pc, {target[31:2], 2'b00});
            end
         end
         tick();
      end
      if (!found) begin
         vectors++;
         miscompares++;
         $display("FAIL collision_timeout: no dequeue within 8 cycles, want one");
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc[3];
      int          n;
      exp_pc[0] = 32'hFFFF_FFF8;
      exp_pc[1] = 32'hFFFF_FFFC;
      exp_pc[2] = 32'h0000_0000;
      drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
      tick();
      n = 0;
      for (int i = 0; i < 12 && n < 3; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1);
         if (deq_valid === 1'b1) begin
            vectors++;
            if (deq_pc !== exp_pc[n]) begin
               miscompares++;
               $display("FAIL wrap_pc%0d: got %h, want %h", n, deq_pc, exp_pc[n]);
            end
            n++;
         end
         tick();
      end
      if (n < 3) begin
         vectors++;
         miscompares++;
         $display("FAIL wrap_timeout: got %0d dequeues, want 3", n);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 20 && !(mq.size() == 2 && mpend); i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b0);
         tick();
      end
      vectors++;
      if (!(mq.size() == 2 && mpend)) begin
         miscompares++;
         $display("FAIL reset_mid_setup: queue=%0d inflight=%b, want 2 and 1", mq.size(), mpend);
      end
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      vectors++;
      if (deq_valid !== 1'b0 || count !== 3'd0 || inst_ram_addr !== RESET_PC || inst_ram_en !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid: valid=%b count=%0d addr=%h en=%b, want 0 0 %h 1",
                  deq_valid, count, inst_ram_addr, inst_ram_en, RESET_PC);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 99) < 2,
               $urandom_range(0, 99) < 6,
               $urandom(),
               $urandom_range(0, 99) < 70);
         tick();
      end
   endtask

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      deq_ready      = 1'b0;
      inst_ram_rdata = '0;
      mfetch         = RESET_PC;
      mpend          = 1'b0;
      mpend_pc       = '0;
      @(negedge clk);
      test_reset();
      test_streaming();
      test_stall();
      test_redirect_mid();
      test_collision();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupled instruction-fetch front end for the 5-stage MIPS pipeline, replacing the single-register IF stage plus IF/ID register pair. It owns the fetch PC and issues one request per cycle to the synchronous instruction RAM. Returned words are buffered in a DEPTH-entry FIFO of {pc, instr} pairs, and ID consumes them through a valid/ready handshake. Branch/jump redirects from ID flush the queue and restart fetch.

## Interface
- `ADDR_W`, 32: PC and RAM address width.
- `DEPTH`, 4: queue entries; power of two, ≥ 2.
- `RESET_PC`, 32'hBFC0_0000: first fetch address after reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `redirect_valid`  in  1  branch/jump taken in ID.
- `redirect_pc`  in  ADDR_W  target; bits [1:0] are ignored and treated as 0.
- `inst_ram_en`  out  1  fetch request this cycle.
- `inst_ram_addr`  out  ADDR_W  request address (current fetch PC).
- `inst_ram_rdata`  in  32  RAM data, valid exactly 1 cycle after a request.
- `deq_valid`  out  1  head entry available to ID.
- `deq_ready`  in  1  ID accepts the head; equals !IF_ID_stall.
- `deq_pc`  out  ADDR_W  head PC; 0 when `deq_valid` = 0.
- `deq_instr`  out  32  head instruction; 0 when `deq_valid` = 0.
- `count`  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- State:
  - `fetch_pc`
  - `inflight` (1 bit) and `inflight_pc`
  - FIFO storage, read pointer, write pointer, and `count`
- Issue rule: `inst_ram_en` = !rst && !redirect_valid && (count + inflight < DEPTH).
  - `count` is the registered value; a same-cycle dequeue gives no credit.
  - On issue: `inflight` ← 1, `inflight_pc` ← `fetch_pc`, `fetch_pc` ← `fetch_pc` + 4, wrapping modulo 2^ADDR_W.
  - With no issue: `inflight` ← 0.
- Return: when `inflight` = 1 and there is no redirect, {`inflight_pc`, `inst_ram_rdata`} is written at the tail. The issue rule guarantees a free slot.
- Dequeue: a handshake (`deq_valid` && `deq_ready`) with no redirect pops the head.
  - A simultaneous pop and write leaves `count` unchanged.
- Redirect, which has priority over everything:
  - `count` ← 0 and pointers ← 0.
  - Returning data is dropped and any same-cycle dequeue is ignored.
  - `inflight` ← 0 and `fetch_pc` ← {`redirect_pc`[ADDR_W-1:2], 2'b00}.
  - No request is issued in the redirect cycle, so no stale response can arrive afterwards.
- Reset: `fetch_pc` = RESET_PC, `inflight` = 0, `count` = 0, pointers = 0, storage = 0.
  - During the reset cycle all outputs are 0: `inst_ram_en`, `inst_ram_addr`, `deq_valid`, `deq_pc`, `deq_instr`, `count`.
  - Reset mid-operation discards all queued and in-flight words.
  - Reset and redirect in the same cycle: reset wins.

## Timing
- RAM read latency is 1 cycle: a request in cycle t returns data in cycle t+1.
- Redirect asserted in cycle t:
  - t+1: `inst_ram_addr` = target with `inst_ram_en` = 1.
  - t+2: data written into the queue.
  - t+3: `deq_valid` = 1, when FETCH_BYPASS_EN is not defined.
- Sustained throughput is one instruction per cycle while `deq_ready` = 1.
- Full: `count` = DEPTH forces `inst_ram_en` = 0; issue resumes the cycle after `count` drops below DEPTH.
- Empty: `deq_valid` = 0, so the `deq_ready` value is don't-care.
- Pointers wrap modulo DEPTH.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When `count` = 0, `inflight` = 1 and there is no redirect, the returning word drives `deq_valid`/`deq_pc`/`deq_instr` combinationally.
  - If `deq_ready` = 1, the word is consumed and not written into the queue; otherwise it is written as normal.
  - Redirect-to-dequeue latency becomes t+2.
- `FETCH_BYPASS_EN` undefined: every word passes through the queue, giving a redirect-to-dequeue latency of t+3.

## Test plan
- Reset release, then `deq_ready` = 1 held:
  - First cycle after reset: `inst_ram_addr` = 0xBFC00000 with `inst_ram_en` = 1.
  - Dequeued PCs are 0xBFC00000, 0xBFC00004, 0xBFC00008, … on consecutive cycles with no bubbles once filled.
- `deq_ready` = 0 for 10 cycles:
  - `count` saturates at 4 and `inst_ram_en` = 0.
  - After release, PCs continue in order with no loss or duplication.
- `redirect_valid` with `redirect_pc` = 0xBFC00103 while `count` = 3:
  - Next cycle: `count` = 0 and `inst_ram_addr` = 0xBFC00100.
  - `deq_valid` rises at t+3 (t+2 with bypass).
- Redirect, returning data and `deq_ready` = 1 in the same cycle:
  - The returning word is dropped and nothing is dequeued.
  - The first dequeued PC afterwards is the redirect target.
- Redirect to 0xFFFFFFF8 with streaming: dequeued PCs are 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- `rst` asserted while `count` = 2 and a request is in flight:
  - The next cycle shows `deq_valid` = 0 and `count` = 0.
  - The following fetch address is 0xBFC00000.
